spm_product_receiver: RTL and testbench
=======================================

# spm_product_receiver

Receiving end of the serial-parallel multiplier's product stream. It collects the SPM's LSB-first serial product bits into a parallel product. It then converts the result to sign plus magnitude and runs a sequential double-dabble to produce BCD digits for the display/scroll path. It sits between the SPM and the display driver, on the divided clock domain used by the control unit.

## Interface
Parameters:
- WIDTH, 16, product width in bits; 2 ≤ WIDTH ≤ 16
- DIGITS, 5, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- clr  input  1  synchronous clear, active-high
- start  input  1  one-cycle pulse: a new product stream follows
- is_signed  input  1  product is two's complement; sampled on accepted start
- bit_valid  input  1  bit_in is a valid product bit this cycle
- bit_in  input  1  serial product bit, LSB first
- busy  output  1  high in RECV and CONV
- done  output  1  one-cycle pulse: outputs updated
- error  output  1  one-cycle pulse: start arrived while busy
- product  output  WIDTH  raw received product
- negative  output  1  signed mode and product MSB = 1
- bcd  output  4*DIGITS  magnitude in BCD, digit 0 in bits [3:0]

## Operation
- States: IDLE, RECV, CONV, DONE.
- IDLE:
  - start → RECV.
  - Clear the bit counter and shift register; latch is_signed.
- RECV:
  - On each bit_valid, shift bit_in into the MSB of the WIDTH-bit shift register and shift right.
  - Increment the bit counter.
  - When the WIDTH-th valid bit is captured → CONV.
  - bit_valid = 0 cycles are gaps: no shift, no count.
- Entry into CONV:
  - Compute magnitude = two's-complement negation if signed and MSB = 1, else the raw value.
  - Width rule: signed 0x8000 gives magnitude 32768, which fits in an unsigned WIDTH-bit register.
- CONV:
  - Exactly WIDTH cycles of double-dabble.
  - Each cycle: add 3 to every BCD digit ≥ 5, then shift {bcd, mag} left by 1.
  - After WIDTH cycles → DONE.
- DONE:
  - One cycle; done = 1; product, negative and bcd registers are loaded on entry.
  - → IDLE unconditionally.
- Outputs hold their values until the next DONE, clr or rst.
- bit_valid outside RECV is ignored.
- start in RECV or CONV:
  - Aborts the current operation and restarts in RECV with a fresh counter; is_signed is re-latched.
  - error pulses for one cycle.
  - Output registers are unchanged.
- start in DONE: accepted as a normal start (→ RECV, no error); done still pulses this cycle.
- clr (any state):
  - Next state IDLE.
  - All outputs and internal registers go to 0.
  - clr takes priority over start and bit_valid in the same cycle.
- rst low (asynchronous, any time including mid-CONV):
  - State IDLE.
  - busy, done, error, negative = 0; product = 0; bcd = 0.

## Timing
- start at edge S:
  - busy high from S.
  - The first bit can be captured at edge S+1.
- Last (WIDTH-th) valid bit captured at edge L:
  - State is CONV from L.
  - DONE is entered at edge L+WIDTH+1.
  - done is high for the single cycle following that edge, and outputs are valid from that same edge.
- Minimum start-to-done with back-to-back bits: 2*WIDTH+2 cycles (WIDTH = 16: 34 cycles).
- busy falls at the edge entering DONE; busy = 0 while done = 1.
- error is registered: high for the cycle after the offending start edge.

## Test plan
- Unsigned 0x3039 streamed LSB first, no gaps:
  - done once, 34 cycles after start.
  - product = 0x3039, negative = 0, bcd = 0x12345.
- Signed 0xFFF6: product = 0xFFF6, negative = 1, bcd = 0x00010. Same bits unsigned: negative = 0, bcd = 0x65526.
- Boundary values:
  - Signed 0x8000 → negative = 1, bcd = 0x32768.
  - Unsigned 0xFFFF → bcd = 0x65535.
  - 0x0000 → bcd = 0x00000, negative = 0.
- Gaps: 0x3039 with bit_valid = 0 for random 0–3 cycles between bits → identical outputs; done 16 cycles after the last bit edge + 1.
- Restart after a first completed product:
  - start after 7 bits, then a full 0x0064 stream → error pulse once, single done.
  - product = 0x0064, bcd = 0x00100.
  - Old outputs held until that done.
- Reset and clear:
  - rst low mid-CONV → all outputs 0 immediately, no done; a following full 0x0001 stream gives bcd = 0x00001.
  - clr and start in the same cycle → IDLE, busy = 0.

Source files
------------

// File: rtl/spm_product_receiver.sv
// Collects an LSB-first serial product, then double-dabbles its sign/magnitude into BCD.
// done follows the last bit by WIDTH+1 cycles; no backpressure, a new start aborts any work in flight.
module spm_product_receiver #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [WIDTH-1:0]      product,
    output logic                  negative,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RECV, CONV, DONE} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [WIDTH-1:0]      shreg;
    logic [WIDTH-1:0]      mag;
    logic [4*DIGITS-1:0]   bcd_acc;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic                  sgn;
    logic [WIDTH-1:0]      shreg_nxt;
    logic                  last_bit;
    logic                  conv_end;

    assign shreg_nxt = {bit_in, shreg[WIDTH-1:1]};
    assign last_bit  = (state == RECV) && bit_valid && (cnt == CW'(WIDTH - 1));
    // CONV holds one extra cycle after the last dabble step so DONE lands at L+WIDTH+1
    assign conv_end  = (state == CONV) && (cnt == CW'(WIDTH));
    assign busy      = (state == RECV) || (state == CONV);
    assign done      = (state == DONE);

    always_comb begin
        bcd_adj = bcd_acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_acc[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) state_nxt = RECV;
                RECV: if (start) state_nxt = RECV;
                      else if (last_bit) state_nxt = CONV;
                CONV: if (start) state_nxt = RECV;
                      else if (conv_end) state_nxt = DONE;
                DONE: state_nxt = start ? RECV : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            shreg    <= '0;
            mag      <= '0;
            bcd_acc  <= '0;
            sgn      <= 1'b0;
            error    <= 1'b0;
            product  <= '0;
            negative <= 1'b0;
            bcd      <= '0;
        end else if (clr) begin
            cnt      <= '0;
            shreg    <= '0;
            mag      <= '0;
            bcd_acc  <= '0;
            sgn      <= 1'b0;
            error    <= 1'b0;
            product  <= '0;
            negative <= 1'b0;
            bcd      <= '0;
        end else begin
            error <= start && ((state == RECV) || (state == CONV));
            if (start) begin
                cnt     <= '0;
                shreg   <= '0;
                mag     <= '0;
                bcd_acc <= '0;
                sgn     <= is_signed;
            end else begin
                case (state)
                    RECV: if (bit_valid) begin
                        shreg <= shreg_nxt;
                        if (last_bit) begin
                            cnt     <= '0;
                            bcd_acc <= '0;
                            mag     <= (sgn && bit_in) ? (~shreg_nxt + WIDTH'(1)) : shreg_nxt;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    CONV: if (conv_end) begin
                        product  <= shreg;
                        negative <= sgn & shreg[WIDTH-1];
                        bcd      <= bcd_acc;
                    end else begin
                        bcd_acc <= {bcd_adj[4*DIGITS-2:0], mag[WIDTH-1]};
                        mag     <= {mag[WIDTH-2:0], 1'b0};
                        cnt     <= cnt + CW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spm_product_receiver.sv
// Directed bench for spm_product_receiver (WIDTH=16, DIGITS=5).
module tb_spm_product_receiver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        busy, done, error, negative;
    logic [15:0] product;
    logic [19:0] bcd;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_cyc = 0;
    logic busy_at_done = 1'b0;
    int t_start, t_last;
    logic [15:0] held_prod;

    spm_product_receiver #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .is_signed(is_signed),
        .bit_valid(bit_valid), .bit_in(bit_in), .busy(busy), .done(done),
        .error(error), .product(product), .negative(negative), .bcd(bcd)
    );

    always #5 clk = ~clk;

    // Edge counter plus done/error pulse monitors, sampled 1ns after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            busy_at_done = busy;
        end
        if (error) err_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // t_start = edge that sampled start; t_last = edge that captured the last bit
    task automatic send_stream(input logic [15:0] v, input logic sgn, input int nbits,
                               input int gapmax, input bit do_wait);
        int g, k, d0;
        @(negedge clk);
        start = 1'b1; is_signed = sgn; bit_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; t_start = cyc;
        for (int i = 0; i < nbits; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            repeat (g) @(negedge clk);
            bit_valid = 1'b1; bit_in = v[i];
            @(negedge clk);
            t_last = cyc; held_prod = product;
            bit_valid = 1'b0;
        end
        bit_in = 1'b0;
        if (do_wait) begin
            d0 = done_cnt; k = 0;
            while (done_cnt == d0 && k < 200) begin
                @(negedge clk);
                k++;
            end
            n_checks++;
            if (done_cnt == d0) begin
                n_fail++;
                $display("FAIL done_timeout: no done within %0d cycles, required one", k);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b need 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b need 0", error); end
        n_checks++; if (product !== 16'h0) begin n_fail++; $display("FAIL reset_product: got %h need 0000", product); end
        n_checks++; if (bcd !== 20'h0)  begin n_fail++; $display("FAIL reset_bcd: got %h need 00000", bcd); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        send_stream(16'h3039, 1'b0, 16, 0, 1'b1);
        @(negedge clk);
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL uns_done_count: got %0d need 1", done_cnt - d0); end
        // start cycle counts as cycle 1, so done shows in cycle 2*16+2
        n_checks++; if (done_cyc - t_start + 1 !== 34) begin n_fail++; $display("FAIL uns_latency: got %0d need 34", done_cyc - t_start + 1); end
        n_checks++; if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL uns_busy_at_done: got %b need 0", busy_at_done); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL uns_no_error: got %0d need 0", err_cnt - e0); end
        n_checks++; if (product !== 16'h3039) begin n_fail++; $display("FAIL uns_product: got %h need 3039", product); end
        n_checks++; if (negative !== 1'b0) begin n_fail++; $display("FAIL uns_negative: got %b need 0", negative); end
        n_checks++; if (bcd !== 20'h12345) begin n_fail++; $display("FAIL uns_bcd: got %h need 12345", bcd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL uns_idle_busy: got %b need 0", busy); end
    endtask

    task automatic test_signed();
        send_stream(16'hFFF6, 1'b1, 16, 0, 1'b1);
        n_checks++; if (product !== 16'hFFF6) begin n_fail++; $display("FAIL sgn_product: got %h need fff6", product); end
        n_checks++; if (negative !== 1'b1) begin n_fail++; $display("FAIL sgn_negative: got %b need 1", negative); end
        n_checks++; if (bcd !== 20'h00010) begin n_fail++; $display("FAIL sgn_bcd: got %h need 00010", bcd); end
        send_stream(16'hFFF6, 1'b0, 16, 0, 1'b1);
        n_checks++; if (negative !== 1'b0) begin n_fail++; $display("FAIL sgn_as_uns_negative: got %b need 0", negative); end
        n_checks++; if (bcd !== 20'h65526) begin n_fail++; $display("FAIL sgn_as_uns_bcd: got %h need 65526", bcd); end
    endtask

    task automatic test_boundaries();
        send_stream(16'h8000, 1'b1, 16, 0, 1'b1);
        n_checks++; if (negative !== 1'b1) begin n_fail++; $display("FAIL min_neg_negative: got %b need 1", negative); end
        n_checks++; if (bcd !== 20'h32768) begin n_fail++; $display("FAIL min_neg_bcd: got %h need 32768", bcd); end
        send_stream(16'hFFFF, 1'b0, 16, 0, 1'b1);
        n_checks++; if (bcd !== 20'h65535) begin n_fail++; $display("FAIL max_uns_bcd: got %h need 65535", bcd); end
        send_stream(16'h0000, 1'b1, 16, 0, 1'b1);
        n_checks++; if (bcd !== 20'h00000) begin n_fail++; $display("FAIL zero_bcd: got %h need 00000", bcd); end
        n_checks++; if (negative !== 1'b0) begin n_fail++; $display("FAIL zero_negative: got %b need 0", negative); end
    endtask

    task automatic test_gaps();
        send_stream(16'h3039, 1'b0, 16, 3, 1'b1);
        n_checks++; if (done_cyc - t_last !== 17) begin n_fail++; $display("FAIL gap_latency: got %0d need 17", done_cyc - t_last); end
        n_checks++; if (product !== 16'h3039) begin n_fail++; $display("FAIL gap_product: got %h need 3039", product); end
        n_checks++; if (bcd !== 20'h12345) begin n_fail++; $display("FAIL gap_bcd: got %h need 12345", bcd); end
    endtask

    task automatic test_restart();
        int d0, e0;
        logic [15:0] old_prod;
        old_prod = product;
        d0 = done_cnt; e0 = err_cnt;
        send_stream(16'h1234, 1'b1, 7, 0, 1'b0);
        send_stream(16'h0064, 1'b0, 16, 0, 1'b1);
        @(negedge clk);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL rs_error_count: got %0d need 1", err_cnt - e0); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rs_done_count: got %0d need 1", done_cnt - d0); end
        n_checks++; if (held_prod !== old_prod) begin n_fail++; $display("FAIL rs_held_product: got %h need %h", held_prod, old_prod); end
        n_checks++; if (product !== 16'h0064) begin n_fail++; $display("FAIL rs_product: got %h need 0064", product); end
        n_checks++; if (bcd !== 20'h00100) begin n_fail++; $display("FAIL rs_bcd: got %h need 00100", bcd); end
    endtask

    task automatic test_reset_mid_conv();
        int d0;
        send_stream(16'h3039, 1'b0, 16, 0, 1'b0);
        repeat (5) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstc_busy: got %b need 0", busy); end
        n_checks++; if (product !== 16'h0) begin n_fail++; $display("FAIL rstc_product: got %h need 0000", product); end
        n_checks++; if (bcd !== 20'h0) begin n_fail++; $display("FAIL rstc_bcd: got %h need 00000", bcd); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rstc_no_done: got %0d need %0d", done_cnt, d0); end
        send_stream(16'h0001, 1'b0, 16, 0, 1'b1);
        n_checks++; if (bcd !== 20'h00001) begin n_fail++; $display("FAIL rstc_after_bcd: got %h need 00001", bcd); end
        n_checks++; if (product !== 16'h0001) begin n_fail++; $display("FAIL rstc_after_product: got %h need 0001", product); end
    endtask

    task automatic test_clr_start();
        int d0, e0;
        send_stream(16'h00FF, 1'b0, 3, 0, 1'b0);
        d0 = done_cnt; e0 = err_cnt;
        start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b need 0", busy); end
        n_checks++; if (product !== 16'h0) begin n_fail++; $display("FAIL clr_product: got %h need 0000", product); end
        n_checks++; if (bcd !== 20'h0) begin n_fail++; $display("FAIL clr_bcd: got %h need 00000", bcd); end
        repeat (40) @(negedge clk);
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL clr_no_error: got %0d need 0", err_cnt - e0); end
        n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL clr_no_done: got %0d need 0", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_boundaries();
        test_gaps();
        test_restart();
        test_reset_mid_conv();
        test_clr_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
